upsp_axis_out_packer: RTL and testbench

- Downstream of the up-sampling core. Consumes the core's 24-bit output pixel stream over a valid/ready handshake.
- Repacks pixels into 32-bit AXI-Stream beats for the output stream slave. Frame start is marked on tuser and end of line on tlast.
- Counts pixels against the configured output frame size and pulses interrupt_updone once the last beat of the frame is accepted downstream.
- Contains a 2-entry skid FIFO, so backpressure is fully registered.

---
 rtl/upsp_axis_out_packer.sv | 130 +++++++++++++
 tb/tb_upsp_axis_out_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsp_axis_out_packer.sv
// rtl/upsp_axis_out_packer.sv - repacks up-sampled pixels into AXI-Stream beats with frame/line markers
module upsp_axis_out_packer #(
    parameter int PIXEL_W = 24,
    parameter int DATA_W  = 32,
    parameter int DIM_W   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIM_W-1:0]      cfg_width,
    input  logic [DIM_W-1:0]      cfg_height,
    input  logic                  cfg_start,
    output logic                  busy,
    input  logic                  upsp_valid,
    input  logic [PIXEL_W-1:0]    upsp_data,
    output logic                  upsp_ready,
    output logic                  m_axis_tvalid,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  interrupt_updone
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam int ENT_W = PIXEL_W + 2;

    logic [1:0]         state;
    logic [DIM_W-1:0]   w_q;
    logic [DIM_W-1:0]   h_q;
    logic [DIM_W-1:0]   x;
    logic [DIM_W-1:0]   y;
    logic [2*DIM_W-1:0] out_cnt;
    logic [2*DIM_W-1:0] total;
    logic               input_done;
    logic [ENT_W-1:0]   mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_count;
    logic               push;
    logic               pop;
    logic               start_ok;
    logic               x_wrap;
    logic               last_pixel;
    logic [ENT_W-1:0]   head;

    assign total      = {{DIM_W{1'b0}}, w_q} * {{DIM_W{1'b0}}, h_q};
    assign start_ok   = cfg_start && (state == ST_IDLE);
    // Ready depends only on local state and occupancy, so downstream stalls never combinationally reach the core.
    assign upsp_ready = (state == ST_RUN) && (fifo_count < 2'd2) && !input_done;
    assign push       = upsp_valid && upsp_ready;
    assign x_wrap     = (x == w_q - DIM_W'(1));
    assign last_pixel = x_wrap && (y == h_q - DIM_W'(1));

    assign head             = mem[rd_ptr];
    assign m_axis_tvalid    = (fifo_count != 2'd0);
    assign m_axis_tdata     = DATA_W'(head[ENT_W-1:2]);
    assign m_axis_tuser     = head[1];
    assign m_axis_tlast     = head[0];
    assign m_axis_tkeep     = '1;
    assign pop              = m_axis_tvalid && m_axis_tready;
    assign busy             = (state != ST_IDLE) || start_ok;
    assign interrupt_updone = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            x          <= '0;
            y          <= '0;
            out_cnt    <= '0;
            input_done <= 1'b0;
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        w_q        <= cfg_width;
                        h_q        <= cfg_height;
                        x          <= '0;
                        y          <= '0;
                        out_cnt    <= '0;
                        input_done <= 1'b0;
                        state      <= (cfg_width == '0 || cfg_height == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push && last_pixel) begin
                        input_done <= 1'b1;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_count == 2'd0 && out_cnt == total)
                        state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase

            if (push) begin
                mem[wr_ptr] <= {upsp_data, (x == '0) && (y == '0), x_wrap};
                wr_ptr      <= ~wr_ptr;
                if (x_wrap) begin
                    x <= '0;
                    y <= y + DIM_W'(1);
                end else begin
                    x <= x + DIM_W'(1);
                end
            end

            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_cnt <= out_cnt + (2*DIM_W)'(1);
            end

            if (push && !pop)
                fifo_count <= fifo_count + 2'd1;
            else if (pop && !push)
                fifo_count <= fifo_count - 2'd1;
        end
    end
endmodule

// File: tb/tb_upsp_axis_out_packer.sv
// tb/tb_upsp_axis_out_packer.sv - randomized self-checking bench for upsp_axis_out_packer
module tb_upsp_axis_out_packer;
    localparam int PIXEL_W = 24;
    localparam int DATA_W  = 32;
    localparam int DIM_W   = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DIM_W-1:0]     cfg_width;
    logic [DIM_W-1:0]     cfg_height;
    logic                 cfg_start;
    logic                 busy;
    logic                 upsp_valid;
    logic [PIXEL_W-1:0]   upsp_data;
    logic                 upsp_ready;
    logic                 m_axis_tvalid;
    logic [DATA_W-1:0]    m_axis_tdata;
    logic [DATA_W/8-1:0]  m_axis_tkeep;
    logic                 m_axis_tuser;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;
    logic                 interrupt_updone;

    always #5 clk = ~clk;

    upsp_axis_out_packer #(.PIXEL_W(PIXEL_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_start(cfg_start), .busy(busy),
        .upsp_valid(upsp_valid), .upsp_data(upsp_data), .upsp_ready(upsp_ready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .interrupt_updone(interrupt_updone)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [PIXEL_W-1:0] src[$];
    logic [DATA_W-1:0]  beat_data[$];
    logic               beat_user[$];
    logic               beat_last[$];
    int                 beat_cyc[$];
    int irq_cnt, irq_cyc, busy_cycles, ready_seen, ready_bad, ready_dropped;
    int stall_seen, stall_bad, timeout, rst_out_bad, acc;

    // Reference: beat i carries pixel i, tuser only on the first pixel, tlast on every line's last column.
    function automatic logic [DATA_W-1:0] exp_data(input int i);
        exp_data = {8'h00, src[i]};
    endfunction
    function automatic logic exp_user(input int i);
        exp_user = (i == 0);
    endfunction
    function automatic logic exp_last(input int i, input int w);
        exp_last = ((i % w) == w - 1);
    endfunction

    task automatic run_frame(input int w, input int h, input int vpct, input int rmode,
                             input int inject_at, input int rst_after);
        int cyc, end_cyc, rst_at, nbeat;
        logic pstall, puser, plast, exp_r;
        logic [DATA_W-1:0] pdata;
        src.delete(); beat_data.delete(); beat_user.delete(); beat_last.delete(); beat_cyc.delete();
        for (int i = 0; i < w * h; i++) src.push_back(PIXEL_W'($urandom));
        irq_cnt = 0; irq_cyc = -1; busy_cycles = 0; ready_seen = 0; ready_bad = 0; ready_dropped = 0;
        stall_seen = 0; stall_bad = 0; timeout = 0; rst_out_bad = 0; acc = 0;
        cyc = 0; end_cyc = -1; rst_at = -1; pstall = 0; puser = 0; plast = 0; pdata = '0;
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_start = 1'b1; rst = 1'b0;
        upsp_valid = (w * h > 0) && ($urandom_range(99) < vpct);
        upsp_data = (w * h > 0) ? src[0] : '0;
        m_axis_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(1)) : 1'b0;
        while (end_cyc < 0 || cyc < end_cyc) begin
            if (cyc > 3000) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
            nbeat = beat_data.size();
            if (busy) busy_cycles++;
            if (interrupt_updone) begin
                irq_cnt++;
                irq_cyc = cyc;
                if (end_cyc < 0) end_cyc = cyc + 3;
            end
            if (upsp_ready) ready_seen = 1;
            if (rmode == 2 && cyc >= 1) begin
                exp_r = (acc < w * h) && (acc - nbeat < 2);
                if (upsp_ready !== exp_r) ready_bad++;
                if (!upsp_ready && acc < w * h) ready_dropped = 1;
            end
            if (rst_at >= 0) begin
                if (cyc == rst_at + 1 && (busy || upsp_ready || m_axis_tvalid || m_axis_tdata != '0 ||
                    m_axis_tuser || m_axis_tlast || interrupt_updone))
                    rst_out_bad++;
            end else begin
                if (pstall) begin
                    stall_seen++;
                    if (m_axis_tdata !== pdata || m_axis_tuser !== puser || m_axis_tlast !== plast)
                        stall_bad++;
                end
                if (upsp_valid && upsp_ready) acc++;
                if (m_axis_tvalid && m_axis_tready) begin
                    beat_data.push_back(m_axis_tdata);
                    beat_user.push_back(m_axis_tuser);
                    beat_last.push_back(m_axis_tlast);
                    beat_cyc.push_back(cyc);
                end
                pstall = m_axis_tvalid && !m_axis_tready;
                pdata = m_axis_tdata; puser = m_axis_tuser; plast = m_axis_tlast;
            end
            @(posedge clk);
            #1;
            cyc++;
            cfg_start = (cyc == inject_at);
            cfg_width = (cyc == inject_at) ? DIM_W'(9) : DIM_W'(w);
            if (rst_after >= 0 && rst_at < 0 && beat_data.size() >= rst_after) begin
                rst = 1'b1;
                rst_at = cyc;
                end_cyc = cyc + 6;
            end else begin
                rst = 1'b0;
            end
            upsp_valid = (rst_at < 0) && (acc < w * h) && ($urandom_range(99) < vpct);
            upsp_data = (acc < w * h) ? src[acc] : '0;
            case (rmode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(1));
                default: m_axis_tready = (cyc >= 6 && cyc <= 10) ? 1'b0 : 1'(cyc % 2);
            endcase
        end
        cfg_start = 1'b0; rst = 1'b0; upsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_start = 1'b0; cfg_width = '0; cfg_height = '0;
        upsp_valid = 1'b0; upsp_data = '0; m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy got=%b want=0", busy); end
        total_cnt++; if (upsp_ready !== 1'b0) begin bad_cnt++; $display("FAIL reset_upsp_ready got=%b want=0", upsp_ready); end
        total_cnt++; if (m_axis_tvalid !== 1'b0) begin bad_cnt++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
        total_cnt++; if (m_axis_tdata !== 32'h0) begin bad_cnt++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
        total_cnt++; if (m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0) begin bad_cnt++; $display("FAIL reset_tuser_tlast got=%b%b want=00", m_axis_tuser, m_axis_tlast); end
        total_cnt++; if (interrupt_updone !== 1'b0) begin bad_cnt++; $display("FAIL reset_irq got=%b want=0", interrupt_updone); end
        total_cnt++; if (m_axis_tkeep !== 4'hF) begin bad_cnt++; $display("FAIL reset_tkeep got=%h want=f", m_axis_tkeep); end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_rate();
        run_frame(4, 2, 100, 0, -1, -1);
        total_cnt++; if (timeout != 0) begin bad_cnt++; $display("FAIL full_timeout got=%0d want=0", timeout); end
        total_cnt++; if (beat_data.size() != 8) begin bad_cnt++; $display("FAIL full_beats got=%0d want=8", beat_data.size()); end
        for (int i = 0; i < beat_data.size() && i < 8; i++) begin
            total_cnt++;
            if (beat_data[i] !== exp_data(i) || beat_user[i] !== exp_user(i) || beat_last[i] !== exp_last(i, 4)) begin
                bad_cnt++;
                $display("FAIL full_beat%0d got=%h/%b/%b want=%h/%b/%b", i, beat_data[i], beat_user[i], beat_last[i],
                         exp_data(i), exp_user(i), exp_last(i, 4));
            end
            total_cnt++;
            if (beat_cyc[i] != beat_cyc[0] + i) begin bad_cnt++; $display("FAIL full_gap%0d got=%0d want=%0d", i, beat_cyc[i], beat_cyc[0] + i); end
        end
        total_cnt++; if (irq_cnt != 1) begin bad_cnt++; $display("FAIL full_irq_cnt got=%0d want=1", irq_cnt); end
        if (beat_cyc.size() == 8) begin
            total_cnt++;
            if (irq_cyc - beat_cyc[7] != 2) begin bad_cnt++; $display("FAIL full_irq_delay got=%0d want=2", irq_cyc - beat_cyc[7]); end
        end
        total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL full_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        run_frame(3, 1, 100, 2, -1, -1);
        total_cnt++; if (timeout != 0) begin bad_cnt++; $display("FAIL bp_timeout got=%0d want=0", timeout); end
        total_cnt++; if (beat_data.size() != 3) begin bad_cnt++; $display("FAIL bp_beats got=%0d want=3", beat_data.size()); end
        for (int i = 0; i < beat_data.size() && i < 3; i++) begin
            total_cnt++;
            if (beat_data[i] !== exp_data(i) || beat_user[i] !== exp_user(i) || beat_last[i] !== exp_last(i, 3)) begin
                bad_cnt++;
                $display("FAIL bp_beat%0d got=%h/%b/%b want=%h/%b/%b", i, beat_data[i], beat_user[i], beat_last[i],
                         exp_data(i), exp_user(i), exp_last(i, 3));
            end
        end
        total_cnt++; if (ready_bad != 0) begin bad_cnt++; $display("FAIL bp_ready_model got=%0d want=0 errors", ready_bad); end
        total_cnt++; if (ready_dropped != 1) begin bad_cnt++; $display("FAIL bp_ready_drop got=%0d want=1", ready_dropped); end
        total_cnt++; if (stall_seen < 5) begin bad_cnt++; $display("FAIL bp_stall_seen got=%0d want>=5", stall_seen); end
        total_cnt++; if (stall_bad != 0) begin bad_cnt++; $display("FAIL bp_stall_stable got=%0d want=0", stall_bad); end
        total_cnt++; if (irq_cnt != 1) begin bad_cnt++; $display("FAIL bp_irq_cnt got=%0d want=1", irq_cnt); end
    endtask

    task automatic test_zero_size();
        run_frame(0, 5, 100, 0, -1, -1);
        total_cnt++; if (timeout != 0) begin bad_cnt++; $display("FAIL zero_timeout got=%0d want=0", timeout); end
        total_cnt++; if (beat_data.size() != 0) begin bad_cnt++; $display("FAIL zero_beats got=%0d want=0", beat_data.size()); end
        total_cnt++; if (ready_seen != 0) begin bad_cnt++; $display("FAIL zero_ready got=%0d want=0", ready_seen); end
        total_cnt++; if (busy_cycles != 2) begin bad_cnt++; $display("FAIL zero_busy_cycles got=%0d want=2", busy_cycles); end
        total_cnt++; if (irq_cnt != 1) begin bad_cnt++; $display("FAIL zero_irq_cnt got=%0d want=1", irq_cnt); end
    endtask

    task automatic test_restart_ignored();
        run_frame(2, 2, 100, 0, 3, -1);
        total_cnt++; if (timeout != 0) begin bad_cnt++; $display("FAIL restart_timeout got=%0d want=0", timeout); end
        total_cnt++; if (beat_data.size() != 4) begin bad_cnt++; $display("FAIL restart_beats got=%0d want=4", beat_data.size()); end
        for (int i = 0; i < beat_data.size() && i < 4; i++) begin
            total_cnt++;
            if (beat_data[i] !== exp_data(i) || beat_user[i] !== exp_user(i) || beat_last[i] !== exp_last(i, 2)) begin
                bad_cnt++;
                $display("FAIL restart_beat%0d got=%h/%b/%b want=%h/%b/%b", i, beat_data[i], beat_user[i], beat_last[i],
                         exp_data(i), exp_user(i), exp_last(i, 2));
            end
        end
        total_cnt++; if (irq_cnt != 1) begin bad_cnt++; $display("FAIL restart_irq_cnt got=%0d want=1", irq_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(4, 2, 100, 0, -1, 3);
        total_cnt++; if (timeout != 0) begin bad_cnt++; $display("FAIL rstmid_timeout got=%0d want=0", timeout); end
        total_cnt++; if (rst_out_bad != 0) begin bad_cnt++; $display("FAIL rstmid_outputs got=%0d want=0 nonzero", rst_out_bad); end
        total_cnt++; if (irq_cnt != 0) begin bad_cnt++; $display("FAIL rstmid_irq got=%0d want=0", irq_cnt); end
        run_frame(1, 2, 100, 0, -1, -1);
        total_cnt++; if (beat_data.size() != 2) begin bad_cnt++; $display("FAIL w1_beats got=%0d want=2", beat_data.size()); end
        for (int i = 0; i < beat_data.size() && i < 2; i++) begin
            total_cnt++;
            if (beat_data[i] !== exp_data(i) || beat_user[i] !== exp_user(i) || beat_last[i] !== 1'b1) begin
                bad_cnt++;
                $display("FAIL w1_beat%0d got=%h/%b/%b want=%h/%b/1", i, beat_data[i], beat_user[i], beat_last[i],
                         exp_data(i), exp_user(i));
            end
        end
        total_cnt++; if (irq_cnt != 1) begin bad_cnt++; $display("FAIL w1_irq_cnt got=%0d want=1", irq_cnt); end
    endtask

    task automatic test_random_frames();
        int w, h, n;
        for (int f = 0; f < 6; f++) begin
            w = $urandom_range(6, 1);
            h = $urandom_range(3, 1);
            n = w * h;
            run_frame(w, h, $urandom_range(100, 30), 1, -1, -1);
            total_cnt++; if (timeout != 0) begin bad_cnt++; $display("FAIL rnd%0d_timeout got=%0d want=0", f, timeout); end
            total_cnt++; if (beat_data.size() != n) begin bad_cnt++; $display("FAIL rnd%0d_beats got=%0d want=%0d", f, beat_data.size(), n); end
            for (int i = 0; i < beat_data.size() && i < n; i++) begin
                total_cnt++;
                if (beat_data[i] !== exp_data(i) || beat_user[i] !== exp_user(i) || beat_last[i] !== exp_last(i, w)) begin
                    bad_cnt++;
                    $display("FAIL rnd%0d_beat%0d got=%h/%b/%b want=%h/%b/%b", f, i, beat_data[i], beat_user[i],
                             beat_last[i], exp_data(i), exp_user(i), exp_last(i, w));
                end
            end
            total_cnt++; if (irq_cnt != 1) begin bad_cnt++; $display("FAIL rnd%0d_irq_cnt got=%0d want=1", f, irq_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_zero_size();
        test_restart_ignored();
        test_reset_mid_frame();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
